regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard.
// Three producers (integer ALU, FPU, load unit) compete for the single
// write port. Grants rotate round-robin so no producer starves, and the
// granted write appears on the registered write port one cycle later.
// A 64-entry scoreboard indexed {float, reg} tracks destinations that
// have been issued but not yet written back. The issue stage queries it
// to decide whether to stall on a read-after-write hazard.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [4:0]        req_reg0,
  input  logic [4:0]        req_reg1,
  input  logic [4:0]        req_reg2,
  input  logic [2:0]        req_float,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [2:0]        ack,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              float,
  input  logic              issue_valid,
  input  logic [4:0]        issue_reg,
  input  logic              issue_float,
  input  logic [4:0]        qry_reg1,
  input  logic [4:0]        qry_reg2,
  input  logic              qry_float,
  output logic              stall,
  output logic [6:0]        pending_cnt
);

  logic [1:0]        rrPtr;
  logic              grantValid;
  logic [1:0]        grantIdx;
  logic [4:0]        selReg;
  logic              selFloat;
  logic [DATA_W-1:0] selData;
  logic              selWritable;
  logic [63:0]       pend;
  logic [63:0]       setVec;
  logic [63:0]       clrVec;
  logic [63:0]       pendNext;
  logic [6:0]        pendCount;

  // Pick the winner by scanning requesters from rrPtr upward, wrapping at 3.
  // Nothing is granted while reset is high, so a request in flight is dropped.
  always_comb begin
    grantValid = !reset && (req != 3'b000);
    grantIdx   = 2'd0;
    case (rrPtr)
      2'd1: begin
        if (req[1])      grantIdx = 2'd1;
        else if (req[2]) grantIdx = 2'd2;
        else             grantIdx = 2'd0;
      end
      2'd2: begin
        if (req[2])      grantIdx = 2'd2;
        else if (req[0]) grantIdx = 2'd0;
        else             grantIdx = 2'd1;
      end
      default: begin
        if (req[0])      grantIdx = 2'd0;
        else if (req[1]) grantIdx = 2'd1;
        else             grantIdx = 2'd2;
      end
    endcase
  end

  // The grant pulse goes straight back to the requester in the same cycle.
  always_comb begin
    ack = 3'b000;
    if (grantValid) ack = 3'b001 << grantIdx;
  end

  // Steer the winning requester's destination and data toward the write port.
  always_comb begin
    selReg   = req_reg0;
    selFloat = req_float[0];
    selData  = req_data0;
    case (grantIdx)
      2'd1: begin
        selReg   = req_reg1;
        selFloat = req_float[1];
        selData  = req_data1;
      end
      2'd2: begin
        selReg   = req_reg2;
        selFloat = req_float[2];
        selData  = req_data2;
      end
      default: begin
      end
    endcase
    selWritable = selFloat || (selReg != 5'd0);
  end

  // Advance the round-robin pointer past the last winner and register the write port.
  // Integer r0 is hardwired to zero, so a grant there is acked but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr     <= 2'd0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      float     <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      if (grantValid) begin
        rrPtr     <= (grantIdx == 2'd2) ? 2'd0 : grantIdx + 2'd1;
        writeReg  <= ADDR_W'(selReg);
        writeData <= selData;
        float     <= selFloat;
        regWrite  <= selWritable;
      end
    end
  end

  // Build the set and clear masks for this cycle's issue and write-back.
  // Integer r0 is never marked pending because it can never be a real hazard.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (!reset && issue_valid && (issue_float || (issue_reg != 5'd0)))
      setVec[{issue_float, issue_reg}] = 1'b1;
    if (grantValid)
      clrVec[{selFloat, selReg}] = 1'b1;
    pendNext = (pend & ~clrVec) | setVec;
  end

  // Scoreboard update; a fresh issue overrides a write-back to the same register,
  // since the newer instruction still owes a result.
  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pendNext;
  end

  // Count pending destinations for occupancy monitoring.
  always_comb begin
    pendCount = '0;
    for (int i = 0; i < 64; i++) pendCount = pendCount + {6'd0, pend[i]};
  end

  assign pending_cnt = pendCount;

  // Hazard check looks only at the registered scoreboard, never at this cycle's traffic.
  assign stall = pend[{qry_float, qry_reg1}] | pend[{qry_float, qry_reg2}];

endmodule
